// File: rtl/alu_arbiter_if.sv
// Request/response handshake bundle between the two ALU requesters, the response
// consumer (master side) and alu_arbiter (slave side).
interface alu_arbiter_if #(
  parameter int DW = 6
);
  logic          req0_valid;
  logic          req0_ready;
  logic [DW-1:0] req0_A;
  logic [DW-1:0] req0_B;
  logic          req0_OP;

  logic          req1_valid;
  logic          req1_ready;
  logic [DW-1:0] req1_A;
  logic [DW-1:0] req1_B;
  logic          req1_OP;

  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_id;
  logic [DW-1:0] rsp_R;
  logic          rsp_CF;
  logic          rsp_SF;
  logic          rsp_ZF;

  modport master (
    output req0_valid, req0_A, req0_B, req0_OP,
    input  req0_ready,
    output req1_valid, req1_A, req1_B, req1_OP,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_R, rsp_CF, rsp_SF, rsp_ZF,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_A, req0_B, req0_OP,
    output req0_ready,
    input  req1_valid, req1_A, req1_B, req1_OP,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_R, rsp_CF, rsp_SF, rsp_ZF,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters, one op in flight.
// Optional per-requester saturating grant counters: define ALU_ARB_STATS_EN.
module alu_arbiter #(
  parameter int DW    = 6,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_arbiter_if.slave     bus,
  output logic [DW-1:0]    ALU_A,
  output logic [DW-1:0]    ALU_B,
  output logic             ALU_OP,
  input  logic [DW-1:0]    ALU_R,
  input  logic             ALU_CF,
  input  logic             ALU_SF,
  input  logic             ALU_ZF,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [DW-1:0] alu_a_q, alu_a_d;
  logic [DW-1:0] alu_b_q, alu_b_d;
  logic          alu_op_q, alu_op_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_id_q, rsp_id_d;
  logic [DW-1:0] rsp_r_q, rsp_r_d;
  logic          rsp_cf_q, rsp_cf_d;
  logic          rsp_sf_q, rsp_sf_d;
  logic          rsp_zf_q, rsp_zf_d;

  logic          grant0;
  logic          grant1;

  // Tie goes to the requester that did not win last; last_q resets to 1 so req0 wins first.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      grant0 = bus.req0_valid && (!bus.req1_valid || last_q);
      grant1 = bus.req1_valid && (!bus.req0_valid || !last_q);
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_r_d     = rsp_r_q;
    rsp_cf_d    = rsp_cf_q;
    rsp_sf_d    = rsp_sf_q;
    rsp_zf_d    = rsp_zf_q;
    case (state_q)
      IDLE: begin
        if (grant0) begin
          alu_a_d  = bus.req0_A;
          alu_b_d  = bus.req0_B;
          alu_op_d = bus.req0_OP;
          rsp_id_d = 1'b0;
          last_d   = 1'b0;
          state_d  = ISSUE;
        end else if (grant1) begin
          alu_a_d  = bus.req1_A;
          alu_b_d  = bus.req1_B;
          alu_op_d = bus.req1_OP;
          rsp_id_d = 1'b1;
          last_d   = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        // ALU inputs have been stable for a full cycle; its outputs are settled here.
        rsp_r_d     = ALU_R;
        rsp_cf_d    = ALU_CF;
        rsp_sf_d    = ALU_SF;
        rsp_zf_d    = ALU_ZF;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_r_q     <= '0;
      rsp_cf_q    <= 1'b0;
      rsp_sf_q    <= 1'b0;
      rsp_zf_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_r_q     <= rsp_r_d;
      rsp_cf_q    <= rsp_cf_d;
      rsp_sf_q    <= rsp_sf_d;
      rsp_zf_q    <= rsp_zf_d;
    end
  end

  assign ALU_A         = alu_a_q;
  assign ALU_B         = alu_b_q;
  assign ALU_OP        = alu_op_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_R     = rsp_r_q;
  assign bus.rsp_CF    = rsp_cf_q;
  assign bus.rsp_SF    = rsp_sf_q;
  assign bus.rsp_ZF    = rsp_zf_q;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    cnt0_d = grant0 ? sat_inc(cnt0_q) : cnt0_q;
    cnt1_d = grant1 ? sat_inc(cnt1_q) : cnt1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`else
  assign grant_cnt0 = '0;
  assign grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: provides the combinational ALU, an event-level reference model
// checked every cycle, and directed scenarios with hand-computed results.
module tb_alu_arbiter;
  localparam int DW    = 6;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef ALU_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] r;
    logic          cf;
    logic          sf;
    logic          zf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.DW(DW)) bus ();

  logic [DW-1:0]    alu_a, alu_b, alu_r;
  logic             alu_op, alu_cf, alu_sf, alu_zf;
  logic [CNT_W-1:0] gc0, gc1;
  res_t             alu_res;

  alu_arbiter #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .ALU_A      (alu_a),
    .ALU_B      (alu_b),
    .ALU_OP     (alu_op),
    .ALU_R      (alu_r),
    .ALU_CF     (alu_cf),
    .ALU_SF     (alu_sf),
    .ALU_ZF     (alu_zf),
    .grant_cnt0 (gc0),
    .grant_cnt1 (gc1)
  );

  // The shared ALU: op0 = (A^B)&(A|B), op1 = A >> B[2:0] with CF = last bit shifted out.
  function automatic res_t alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic op);
    res_t o;
    logic [2*DW-1:0] t;
    if (!op) begin
      o.r  = (a ^ b) & (a | b);
      o.cf = 1'b0;
    end else begin
      t    = {a, {DW{1'b0}}} >> b[2:0];
      o.r  = t[2*DW-1:DW];
      o.cf = t[DW-1];
    end
    o.sf = o.r[DW-1];
    o.zf = (o.r == '0);
    return o;
  endfunction

  assign alu_res = alu_fn(alu_a, alu_b, alu_op);
  assign alu_r   = alu_res.r;
  assign alu_cf  = alu_res.cf;
  assign alu_sf  = alu_res.sf;
  assign alu_zf  = alu_res.zf;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: arbiter is either free or owns one op; a response appears one edge
  // after acceptance and is released on the edge where the consumer is ready.
  bit            m_busy, m_pending, m_rsp_valid, m_last, m_id;
  logic [DW-1:0] m_a, m_b;
  logic          m_op;
  res_t          m_res;
  int            m_c0, m_c1;

  always @(negedge clk) begin
    logic e0, e1;
    if (!rst_n) begin
      m_busy = 0; m_pending = 0; m_rsp_valid = 0; m_last = 1; m_id = 0;
      m_a = '0; m_b = '0; m_op = 1'b0; m_res = '0; m_c0 = 0; m_c1 = 0;
    end
    e0 = !m_busy && bus.req0_valid && (!bus.req1_valid || m_last);
    e1 = !m_busy && bus.req1_valid && (!bus.req0_valid || !m_last);
    chk("req0_ready", bus.req0_ready, e0);
    chk("req1_ready", bus.req1_ready, e1);
    chk("rsp_valid", bus.rsp_valid, m_rsp_valid);
    chk("rsp_id", bus.rsp_id, m_id);
    chk("rsp_R", bus.rsp_R, m_res.r);
    chk("rsp_flags", {bus.rsp_CF, bus.rsp_SF, bus.rsp_ZF}, {m_res.cf, m_res.sf, m_res.zf});
    chk("ALU_ops", {alu_a, alu_b, alu_op}, {m_a, m_b, m_op});
    chk("grant_cnt0", gc0, STATS ? m_c0 : 0);
    chk("grant_cnt1", gc1, STATS ? m_c1 : 0);
    if (rst_n) begin
      if (e0 || e1) begin
        m_busy = 1; m_pending = 1; m_id = e1; m_last = e1;
        m_a  = e1 ? bus.req1_A  : bus.req0_A;
        m_b  = e1 ? bus.req1_B  : bus.req0_B;
        m_op = e1 ? bus.req1_OP : bus.req0_OP;
        if (e0 && m_c0 < CMAX) m_c0++;
        if (e1 && m_c1 < CMAX) m_c1++;
      end else if (m_pending) begin
        m_pending   = 0;
        m_res       = alu_fn(m_a, m_b, m_op);
        m_rsp_valid = 1;
      end else if (m_rsp_valid && bus.rsp_ready) begin
        m_rsp_valid = 0;
        m_busy      = 0;
      end
    end
  end

  task automatic wait_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int id, input logic v, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic op);
    if (id == 0) begin
      bus.req0_valid = v; bus.req0_A = a; bus.req0_B = b; bus.req0_OP = op;
    end else begin
      bus.req1_valid = v; bus.req1_A = a; bus.req1_B = b; bus.req1_OP = op;
    end
  endtask

  // Waits (bounded) for the requester's ready; returns 1 at the negedge before the accept edge.
  task automatic wait_ready(input int id, output logic acc);
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if ((id == 0) ? bus.req0_ready : bus.req1_ready) acc = 1'b1;
    end
    chk("accept", acc, 1);
  endtask

  task automatic do_op(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic op, output res_t got, output logic gid);
    logic acc;
    wait_edge();
    set_req(id, 1'b1, a, b, op);
    wait_ready(id, acc);
    wait_edge();
    set_req(id, 1'b0, a, b, op);
    got = '0;
    gid = 1'b0;
    if (acc) begin
      @(negedge clk); chk("latency_issue", bus.rsp_valid, 0);
      @(negedge clk); chk("latency_resp", bus.rsp_valid, 1);
      got = {bus.rsp_R, bus.rsp_CF, bus.rsp_SF, bus.rsp_ZF};
      gid = bus.rsp_id;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded limit %0d", $time, 200000);
    $fatal(1);
  end

  initial begin
    res_t got;
    logic gid, acc;
    int   gids[$];
    int   gcyc[$];

    set_req(0, 1'b0, '0, '0, 1'b0);
    set_req(1, 1'b0, '0, '0, 1'b0);
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    @(negedge clk);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_alu_a", alu_a, 0);
    chk("reset_rsp_R", bus.rsp_R, 0);

    // 1: 101010 op0 010101 -> 111111
    do_op(0, 6'b101010, 6'b010101, 1'b0, got, gid);
    chk("t1_R", got.r, 6'b111111);
    chk("t1_SF_ZF", {got.sf, got.zf}, 2'b10);
    chk("t1_id", gid, 0);

    // 2: 101011 >> 1 -> 010101, bit shifted out is 1
    do_op(1, 6'b101011, 6'b000001, 1'b1, got, gid);
    chk("t2_R", got.r, 6'b010101);
    chk("t2_CF_SF_ZF", {got.cf, got.sf, got.zf}, 3'b100);
    chk("t2_id", gid, 1);

    // 3: zero operands -> zero flag
    do_op(0, 6'b000000, 6'b000000, 1'b0, got, gid);
    chk("t3_R", got.r, 0);
    chk("t3_SF_ZF", {got.sf, got.zf}, 2'b01);

    // 4: both requesters continuously valid after a fresh reset
    wait_edge(); rst_n = 1'b0;
    wait_edge(); rst_n = 1'b1;
    set_req(0, 1'b1, 6'b000011, 6'b000101, 1'b0);
    set_req(1, 1'b1, 6'b111000, 6'b000010, 1'b1);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (bus.req0_ready) begin gids.push_back(0); gcyc.push_back(i); end
      if (bus.req1_ready) begin gids.push_back(1); gcyc.push_back(i); end
    end
    wait_edge();
    set_req(0, 1'b0, '0, '0, 1'b0);
    set_req(1, 1'b0, '0, '0, 1'b0);
    chk("t4_grant_count", gids.size() >= 4, 1);
    for (int k = 0; k < 4 && k < gids.size(); k++) begin
      chk("t4_grant_id", gids[k], k % 2);
      if (k > 0) chk("t4_grant_gap", gcyc[k] - gcyc[k-1], 3);
    end
    repeat (4) wait_edge();

    // 5: consumer stalls; response holds and nobody is accepted
    bus.rsp_ready = 1'b0;
    do_op(0, 6'b110000, 6'b000010, 1'b1, got, gid);
    chk("t5_R", got.r, 6'b001100);
    wait_edge();
    set_req(1, 1'b1, 6'b000001, 6'b000001, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_hold_valid", bus.rsp_valid, 1);
      chk("t5_hold_R", bus.rsp_R, 6'b001100);
      chk("t5_hold_readies", {bus.req0_ready, bus.req1_ready}, 2'b00);
    end
    wait_edge();
    bus.rsp_ready = 1'b1;
    @(negedge clk); chk("t5_still_valid", bus.rsp_valid, 1);
    @(negedge clk); chk("t5_released", bus.rsp_valid, 0);
    chk("t5_idle_ready1", bus.req1_ready, 1);
    wait_edge();
    set_req(1, 1'b0, '0, '0, 1'b0);
    repeat (3) wait_edge();

    // 6: reset while the op is in ISSUE discards it
    set_req(0, 1'b1, 6'b101010, 6'b000000, 1'b0);
    wait_ready(0, acc);
    wait_edge();
    set_req(0, 1'b0, '0, '0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk); chk("t6_rst_valid", bus.rsp_valid, 0);
    wait_edge();
    @(negedge clk); chk("t6_rst_alu_a", alu_a, 0);
    wait_edge();
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk); chk("t6_no_rsp", bus.rsp_valid, 0);
    end
    // 011100 >> 3 -> 000011, bit shifted out is A[2] = 1
    do_op(1, 6'b011100, 6'b000011, 1'b1, got, gid);
    chk("t6_R", got.r, 6'b000011);
    chk("t6_CF", got.cf, 1);
    chk("t6_id", gid, 1);

`ifdef ALU_ARB_STATS_EN
    wait_edge(); rst_n = 1'b0;
    wait_edge(); rst_n = 1'b1;
    for (int i = 0; i < 300; i++) do_op(0, 6'(i), 6'b000001, 1'b0, got, gid);
    @(negedge clk);
    chk("stats_sat_cnt0", gc0, CMAX);
    chk("stats_cnt1", gc1, 0);
`else
    @(negedge clk);
    chk("stats_off_cnt0", gc0, 0);
`endif

    repeat (2) wait_edge();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
